mem_arbiter: RTL and testbench

- Shares the single external 8-bit program/data memory between two requesters:
  - the CPU core's memory port (fetch/execute reads and writes);
  - the front-panel loader port (manual program load/inspect).
- Serialises accesses, generates the memory read/write strobes with a programmable number of wait states, and returns read data with a one-cycle acknowledge.
- Sits between the CPU top level and the memory; the CPU's read/write/addr/data_out signals feed the c_* port.

---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/mem_arbiter_arb_wait_cnt.sv | 27 ++
 rtl/mem_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and default widths for the two-port memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned AW_DEF = 16;
  localparam int unsigned DW_DEF = 8;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic {
    SEL_CPU = 1'b0,
    SEL_PNL = 1'b1
  } sel_t;

endpackage

// File: rtl/mem_arbiter_arb_wait_cnt.sv
// Loadable down-counter timing the strobe phase of each memory access.
module arb_wait_cnt
  import mem_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero_c
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the CPU and front-panel ports onto one external memory with
// programmable wait states. Define ARB_RR_EN for round-robin arbitration.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned WAIT_CYC = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_ack,
  input  logic          p_req,
  input  logic          p_we,
  input  logic [AW-1:0] p_addr,
  input  logic [DW-1:0] p_wdata,
  output logic          p_ack,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_read,
  output logic          mem_write,
  output logic          busy
);

  state_t state;
  sel_t   sel_q;
  sel_t   sel_c;
  logic   op_we;
  logic   any_req_c;
  logic   cnt_load_c;
  logic   cnt_en_c;
  logic   cnt_zero_c;
  logic   win_we_c;
`ifdef ARB_RR_EN
  sel_t   last_sel;
`endif

  assign any_req_c  = c_req | p_req;
  assign cnt_load_c = (state == IDLE) && any_req_c;
  assign cnt_en_c   = (state == ACCESS);
  assign win_we_c   = (sel_c == SEL_CPU) ? c_we : p_we;

  // Winner selection; only meaningful while some request is high.
  always_comb begin
    sel_c = c_req ? SEL_CPU : SEL_PNL;
`ifdef ARB_RR_EN
    if (c_req && p_req) begin
      sel_c = (last_sel == SEL_CPU) ? SEL_PNL : SEL_CPU;
    end
`endif
  end

  arb_wait_cnt u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load_c),
    .en       (cnt_en_c),
    .load_val (CNT_W'(WAIT_CYC)),
    .zero_c   (cnt_zero_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      sel_q     <= SEL_PNL;
      op_we     <= 1'b0;
      c_ack     <= 1'b0;
      p_ack     <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      busy      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
`ifdef ARB_RR_EN
      last_sel  <= SEL_PNL;
`endif
    end else begin
      c_ack <= 1'b0;
      p_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req_c) begin
            sel_q     <= sel_c;
            op_we     <= win_we_c;
            mem_addr  <= (sel_c == SEL_CPU) ? c_addr : p_addr;
            mem_wdata <= (sel_c == SEL_CPU) ? c_wdata : p_wdata;
            mem_read  <= ~win_we_c;
            mem_write <= win_we_c;
            busy      <= 1'b1;
            state     <= ACCESS;
`ifdef ARB_RR_EN
            last_sel  <= sel_c;
`endif
          end
        end
        ACCESS: begin
          // Last strobe cycle: sample read data and raise the ack.
          if (cnt_zero_c) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (!op_we) begin
              rdata <= mem_rdata;
            end
            c_ack <= (sel_q == SEL_CPU);
            p_ack <= (sel_q == SEL_PNL);
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: WAIT_CYC=1 instance plus a WAIT_CYC=0 instance.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        c_req = 0, c_we = 0, p_req = 0, p_we = 0;
  logic [15:0] c_addr = 0, p_addr = 0;
  logic [7:0]  c_wdata = 0, p_wdata = 0, mem_rdata = 0;
  logic        c_ack, p_ack, mem_read, mem_write, busy;
  logic [7:0]  rdata, mem_wdata;
  logic [15:0] mem_addr;

  logic        z_c_req = 0, z_c_we = 0, z_p_req = 0, z_p_we = 0;
  logic [15:0] z_c_addr = 0, z_p_addr = 0;
  logic [7:0]  z_c_wdata = 0, z_p_wdata = 0, z_mem_rdata = 0;
  logic        z_c_ack, z_p_ack, z_mem_read, z_mem_write, z_busy;
  logic [7:0]  z_rdata, z_mem_wdata;
  logic [15:0] z_mem_addr;

  mem_arbiter #(.AW(16), .DW(8), .WAIT_CYC(1)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_ack(c_ack),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata), .p_ack(p_ack),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .busy(busy)
  );

  mem_arbiter #(.AW(16), .DW(8), .WAIT_CYC(0)) dut0 (
    .clk(clk), .rst(rst),
    .c_req(z_c_req), .c_we(z_c_we), .c_addr(z_c_addr), .c_wdata(z_c_wdata), .c_ack(z_c_ack),
    .p_req(z_p_req), .p_we(z_p_we), .p_addr(z_p_addr), .p_wdata(z_p_wdata), .p_ack(z_p_ack),
    .rdata(z_rdata), .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata), .mem_rdata(z_mem_rdata),
    .mem_read(z_mem_read), .mem_write(z_mem_write), .busy(z_busy)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic        pnl;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  mrd;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t vecs[5];

  // One WAIT_CYC=1 transfer: strobes in cycles 1..2, ack in cycle 3.
  task automatic run_vec(input vec_t v, input int idx);
    logic strobe;
    @(posedge clk); #1;
    if (v.pnl) begin
      p_req = 1; p_we = v.we; p_addr = v.addr; p_wdata = v.wdata;
    end else begin
      c_req = 1; c_we = v.we; c_addr = v.addr; c_wdata = v.wdata;
    end
    mem_rdata = v.mrd;
    for (int cyc = 0; cyc <= 4; cyc++) begin
      @(negedge clk);
      strobe = (cyc >= 1 && cyc <= 2);
      check($sformatf("v%0d mem_read c%0d", idx, cyc), 32'(mem_read), 32'(strobe && !v.we));
      check($sformatf("v%0d mem_write c%0d", idx, cyc), 32'(mem_write), 32'(strobe && v.we));
      check($sformatf("v%0d busy c%0d", idx, cyc), 32'(busy), 32'(cyc >= 1 && cyc <= 3));
      check($sformatf("v%0d c_ack c%0d", idx, cyc), 32'(c_ack), 32'(cyc == 3 && !v.pnl));
      check($sformatf("v%0d p_ack c%0d", idx, cyc), 32'(p_ack), 32'(cyc == 3 && v.pnl));
      if (strobe) begin
        check($sformatf("v%0d mem_addr c%0d", idx, cyc), 32'(mem_addr), 32'(v.addr));
        if (v.we) check($sformatf("v%0d mem_wdata c%0d", idx, cyc), 32'(mem_wdata), 32'(v.wdata));
      end
      if (cyc == 3) begin
        check($sformatf("v%0d rdata", idx), 32'(rdata), 32'(v.exp_rd));
        c_req = 0; p_req = 0;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " c_ack"}, 32'(c_ack), 0);
    check({tag, " p_ack"}, 32'(p_ack), 0);
    check({tag, " mem_read"}, 32'(mem_read), 0);
    check({tag, " mem_write"}, 32'(mem_write), 0);
    check({tag, " busy"}, 32'(busy), 0);
    check({tag, " mem_addr"}, 32'(mem_addr), 0);
    check({tag, " mem_wdata"}, 32'(mem_wdata), 0);
    check({tag, " rdata"}, 32'(rdata), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t rv;
    logic order [3];

    vecs[0] = '{pnl: 1'b0, we: 1'b0, addr: 16'h0010, wdata: 8'h00, mrd: 8'hA5, exp_rd: 8'hA5};
    vecs[1] = '{pnl: 1'b1, we: 1'b1, addr: 16'h00FF, wdata: 8'h3C, mrd: 8'h77, exp_rd: 8'hA5};
    vecs[2] = '{pnl: 1'b0, we: 1'b1, addr: 16'h1234, wdata: 8'h5A, mrd: 8'h11, exp_rd: 8'hA5};
    vecs[3] = '{pnl: 1'b1, we: 1'b0, addr: 16'hABCD, wdata: 8'h00, mrd: 8'hC3, exp_rd: 8'hC3};
    vecs[4] = '{pnl: 1'b0, we: 1'b0, addr: 16'hFFFF, wdata: 8'h00, mrd: 8'h0F, exp_rd: 8'h0F};
`ifdef ARB_RR_EN
    order[0] = 1'b0; order[1] = 1'b1; order[2] = 1'b0;
`else
    order[0] = 1'b0; order[1] = 1'b0; order[2] = 1'b0;
`endif

    // Reset state
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    check("rst z_mem_read", 32'(z_mem_read), 0);
    check("rst z_c_ack", 32'(z_c_ack), 0);
    check("rst z_busy", 32'(z_busy), 0);
    check("rst z_rdata", 32'(z_rdata), 0);
    rst = 1;
    @(negedge clk);
    check_reset_outputs("post_rst");

    // Simultaneous requests: CPU first (ack c3), panel next (ack c7)
    @(posedge clk); #1;
    c_req = 1; c_we = 0; c_addr = 16'h0100;
    p_req = 1; p_we = 0; p_addr = 16'h0200;
    mem_rdata = 8'h42;
    for (int cyc = 0; cyc <= 8; cyc++) begin
      @(negedge clk);
      check($sformatf("both c_ack c%0d", cyc), 32'(c_ack), 32'(cyc == 3));
      check($sformatf("both p_ack c%0d", cyc), 32'(p_ack), 32'(cyc == 7));
      if (cyc >= 1 && cyc <= 2) check($sformatf("both addr c%0d", cyc), 32'(mem_addr), 32'h0100);
      if (cyc >= 5 && cyc <= 6) check($sformatf("both addr c%0d", cyc), 32'(mem_addr), 32'h0200);
      if (cyc == 4) check("both idle gap busy", 32'(busy), 0);
      if (cyc == 3) c_req = 0;
      if (cyc == 7) begin
        check("both p rdata", 32'(rdata), 32'h42);
        p_req = 0;
      end
    end

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Request withdrawn and inputs changed after grant: access still completes
    @(posedge clk); #1;
    c_req = 1; c_we = 1; c_addr = 16'h0300; c_wdata = 8'h99;
    for (int cyc = 0; cyc <= 4; cyc++) begin
      @(negedge clk);
      check($sformatf("wd c_ack c%0d", cyc), 32'(c_ack), 32'(cyc == 3));
      check($sformatf("wd mem_write c%0d", cyc), 32'(mem_write), 32'(cyc >= 1 && cyc <= 2));
      if (cyc == 1) begin
        c_req = 0; c_addr = 16'h0400; c_wdata = 8'h00;
      end
      if (cyc == 2) begin
        check("wd mem_addr latched", 32'(mem_addr), 32'h0300);
        check("wd mem_wdata latched", 32'(mem_wdata), 32'h99);
      end
      if (cyc == 3) check("wd rdata unchanged", 32'(rdata), 32'h0F);
    end

    // Reset during ACCESS: strobe drops at once, no ack
    @(posedge clk); #1;
    c_req = 1; c_we = 0; c_addr = 16'h0500; mem_rdata = 8'hEE;
    @(negedge clk);
    @(negedge clk);
    check("rma mem_read before", 32'(mem_read), 1);
    rst = 0;
    #1;
    check("rma mem_read async", 32'(mem_read), 0);
    check("rma busy async", 32'(busy), 0);
    c_req = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("rma no c_ack %0d", k), 32'(c_ack), 0);
    end
    rst = 1;
    @(negedge clk);
    check_reset_outputs("rma_idle");
    rv = '{pnl: 1'b0, we: 1'b0, addr: 16'h0500, wdata: 8'h00, mrd: 8'hEE, exp_rd: 8'hEE};
    run_vec(rv, 9);

    // Three contention rounds after a fresh reset
    @(negedge clk); rst = 0;
    @(negedge clk); rst = 1;
    for (int r = 0; r < 3; r++) begin
      @(posedge clk); #1;
      c_req = 1; c_we = 0; c_addr = 16'h0A00;
      p_req = 1; p_we = 0; p_addr = 16'h0B00;
      for (int cyc = 0; cyc <= 4; cyc++) begin
        @(negedge clk);
        if (cyc == 1) check($sformatf("rr%0d mem_addr", r), 32'(mem_addr),
                            order[r] ? 32'h0B00 : 32'h0A00);
        check($sformatf("rr%0d c_ack c%0d", r, cyc), 32'(c_ack), 32'(cyc == 3 && !order[r]));
        check($sformatf("rr%0d p_ack c%0d", r, cyc), 32'(p_ack), 32'(cyc == 3 && order[r]));
        if (cyc == 3) begin
          c_req = 0; p_req = 0;
        end
      end
    end

    // WAIT_CYC=0: single strobe cycle, ack in cycle 2, no address wrap
    @(posedge clk); #1;
    z_c_req = 1; z_c_we = 0; z_c_addr = 16'hFFFF; z_mem_rdata = 8'h5B;
    for (int cyc = 0; cyc <= 3; cyc++) begin
      @(negedge clk);
      check($sformatf("w0 mem_read c%0d", cyc), 32'(z_mem_read), 32'(cyc == 1));
      check($sformatf("w0 c_ack c%0d", cyc), 32'(z_c_ack), 32'(cyc == 2));
      check($sformatf("w0 p_ack c%0d", cyc), 32'(z_p_ack), 0);
      check($sformatf("w0 busy c%0d", cyc), 32'(z_busy), 32'(cyc == 1 || cyc == 2));
      if (cyc == 1) check("w0 mem_addr", 32'(z_mem_addr), 32'hFFFF);
      if (cyc == 2) begin
        check("w0 rdata", 32'(z_rdata), 32'h5B);
        z_c_req = 0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
